// File: rtl/hub75_scan_driver_if.sv
// Display read port between the HUB75 scan driver and the pixel memory.
// The driver issues column/row/plane addresses; plane bits come back one cycle later.
interface hub75_scan_driver_if;
  logic [5:0] col_addr;
  logic [4:0] row_addr;
  logic [1:0] bcm_phase;
  logic       R1, G1, B1, R2, G2, B2;

  modport master (
    output col_addr, row_addr, bcm_phase,
    input  R1, G1, B1, R2, G2, B2
  );

  modport slave (
    input  col_addr, row_addr, bcm_phase,
    output R1, G1, B1, R2, G2, B2
  );
endinterface

// File: rtl/hub75_scan_driver.sv
// 64x64 1/32-scan HUB75 driver with 4-plane BCM: shifts a row/plane, blanks,
// latches, then shows for BCM_BASE << plane cycles before moving on.
module hub75_scan_driver #(
  parameter int unsigned BCM_BASE     = 64,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  hub75_scan_driver_if.master        mem,
  output logic                       p_r1,
  output logic                       p_g1,
  output logic                       p_b1,
  output logic                       p_r2,
  output logic                       p_g2,
  output logic                       p_b2,
  output logic                       p_clk,
  output logic                       p_lat,
  output logic                       p_oe_n,
  output logic [4:0]                 p_addr,
  output logic                       frame_start
);

  localparam int unsigned SHOW_MAX   = BCM_BASE << 3;
  localparam int unsigned NEED_W     = $clog2(SHOW_MAX) + 1;
  localparam int unsigned CNT_W      = (NEED_W > 10) ? NEED_W : 10;
  localparam int unsigned SHIFT_LAST = 129;
  localparam int unsigned FILL_LAST  = 127;

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, SHOW} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   show_last;
  logic [5:0]         col_q;
  logic [4:0]         row_q, row_d;
  logic [1:0]         phase_q, phase_d;

  assign show_last     = CNT_W'((BCM_BASE << phase_q) - 1);
  assign mem.col_addr  = col_q;
  assign mem.row_addr  = row_q;
  assign mem.bcm_phase = phase_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    phase_d = phase_q;
    case (state_q)
      IDLE:  if (en) state_d = SHIFT;
      SHIFT: if (cnt_q == CNT_W'(SHIFT_LAST)) state_d = BLANK;
      BLANK: if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = LATCH;
      LATCH: state_d = SHOW;
      SHOW: begin
        if (cnt_q == show_last) begin
          if (phase_q != 2'd3) begin
            phase_d = phase_q + 2'd1;
          end else begin
            phase_d = '0;
            row_d   = row_q + 5'd1;
          end
          state_d = en ? SHIFT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      phase_q     <= '0;
      p_r1        <= 1'b0;
      p_g1        <= 1'b0;
      p_b1        <= 1'b0;
      p_r2        <= 1'b0;
      p_g2        <= 1'b0;
      p_b2        <= 1'b0;
      p_clk       <= 1'b0;
      p_lat       <= 1'b0;
      p_oe_n      <= 1'b1;
      p_addr      <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      phase_q <= phase_d;

      if (state_d != state_q || state_q == IDLE) cnt_q <= '0;
      else                                       cnt_q <= cnt_q + CNT_W'(1);

      // Column k is presented for SHIFT cycles 2k and 2k+1, then held at 63.
      if (state_q == SHOW && state_d != SHOW)
        col_q <= '0;
      else if (state_q == SHIFT && cnt_q[0] && col_q != 6'd63)
        col_q <= col_q + 6'd1;

      // Memory data seen in odd cycle 2k+1 belongs to column k.
      if (state_q == SHIFT && cnt_q[0] && cnt_q <= CNT_W'(FILL_LAST)) begin
        p_r1 <= mem.R1;
        p_g1 <= mem.G1;
        p_b1 <= mem.B1;
        p_r2 <= mem.R2;
        p_g2 <= mem.G2;
        p_b2 <= mem.B2;
      end

      p_clk  <= (state_q == SHIFT) && !cnt_q[0] && (cnt_q >= CNT_W'(2));
      p_lat  <= (state_d == LATCH);
      p_oe_n <= (state_d != SHOW);
      if (state_d == LATCH && state_q != LATCH) p_addr <= row_q;
      frame_start <= (state_d == SHIFT) && (state_q != SHIFT) &&
                     (row_d == '0) && (phase_d == '0);
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Self-checking bench for hub75_scan_driver: random pixel memory, per-plane
// expectations from a table, plus reset, frame-interval and enable-drop sequences.
module tb_hub75_scan_driver;
  localparam int BASE      = 64;
  localparam int BLANK     = 4;
  localparam int SHIFT_LEN = 130;
  localparam int NVEC      = 132;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic p_r1, p_g1, p_b1, p_r2, p_g2, p_b2;
  logic p_clk, p_lat, p_oe_n, frame_start;
  logic [4:0] p_addr;
  logic [5:0] mem_q = '0;
  logic [5:0] pix [32][64][4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_times[$];

  typedef struct {
    int row;
    int plane;
    int drop_at;
    int idle_after;
    int exp_show;
    int exp_period;
    int exp_fs;
  } vec_t;

  vec_t tbl[NVEC];

  hub75_scan_driver_if mif ();

  hub75_scan_driver #(.BCM_BASE(BASE), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mem(mif),
    .p_r1(p_r1), .p_g1(p_g1), .p_b1(p_b1),
    .p_r2(p_r2), .p_g2(p_g2), .p_b2(p_b2),
    .p_clk(p_clk), .p_lat(p_lat), .p_oe_n(p_oe_n),
    .p_addr(p_addr), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory: synchronous read, one cycle of latency.
  always @(posedge clk) mem_q <= pix[mif.row_addr][mif.col_addr][mif.bcm_phase];
  assign mif.R1 = mem_q[5];
  assign mif.G1 = mem_q[4];
  assign mif.B1 = mem_q[3];
  assign mif.R2 = mem_q[2];
  assign mif.G2 = mem_q[1];
  assign mif.B2 = mem_q[0];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] panel_bits();
    return {p_r1, p_g1, p_b1, p_r2, p_g2, p_b2};
  endfunction

  // Entered at the falling edge of the first SHIFT cycle of a plane; returns at
  // the falling edge right after its SHOW window ends.
  task automatic observe_plane(input vec_t v);
    int t = 0, rises = 0, lat_n = 0, lat_t = -1, lat_addr = -1;
    int oe_low = 0, oe_first = -1, fs_n = 0, fs_t = -1, derr = 0, aerr = 0;
    logic prev_clk = 1'b0;
    logic seen_low = 1'b0;
    logic done = 1'b0;
    string tag = $sformatf("r%0d_p%0d", v.row, v.plane);
    while (!done) begin
      if (seen_low && p_oe_n) begin
        done = 1'b1;
      end else begin
        if (frame_start) begin
          fs_n++;
          fs_t = t;
          fs_times.push_back(cyc);
        end
        if (p_clk && !prev_clk) begin
          if (rises > 63 || panel_bits() != pix[v.row][rises][v.plane]) derr++;
          rises++;
        end
        prev_clk = p_clk;
        if (t < SHIFT_LEN && (int'(mif.row_addr) != v.row || int'(mif.bcm_phase) != v.plane))
          aerr++;
        if (p_lat) begin
          lat_n++;
          lat_t = t;
          lat_addr = int'(p_addr);
        end
        if (!p_oe_n) begin
          if (!seen_low) oe_first = t;
          seen_low = 1'b1;
          oe_low++;
          if (oe_low == v.drop_at) en = 1'b0;
        end
        @(negedge clk);
        t++;
        if (t > 3000) begin
          checks++;
          errors++;
          $display("FAIL plane_timeout_%s actual=%0d required=%0d", tag, t, v.exp_period);
          done = 1'b1;
        end
      end
    end
    chk({"period_", tag}, t, v.exp_period);
    chk({"show_len_", tag}, oe_low, v.exp_show);
    chk({"show_start_", tag}, oe_first, SHIFT_LEN + BLANK + 1);
    chk({"pclk_rises_", tag}, rises, 64);
    chk({"pixel_data_errs_", tag}, derr, 0);
    chk({"addr_errs_", tag}, aerr, 0);
    chk({"lat_count_", tag}, lat_n, 1);
    chk({"lat_cycle_", tag}, lat_t, SHIFT_LEN + BLANK);
    chk({"lat_p_addr_", tag}, lat_addr, v.row);
    chk({"frame_start_count_", tag}, fs_n, v.exp_fs);
    if (v.exp_fs != 0) chk({"frame_start_cycle_", tag}, fs_t, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_p_oe_n"}, int'(p_oe_n), 1);
    chk({tag, "_p_clk"}, int'(p_clk), 0);
    chk({tag, "_p_lat"}, int'(p_lat), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_p_addr"}, int'(p_addr), 0);
    chk({tag, "_panel_data"}, int'(panel_bits()), 0);
    chk({tag, "_col_addr"}, int'(mif.col_addr), 0);
    chk({tag, "_row_addr"}, int'(mif.row_addr), 0);
    chk({tag, "_bcm_phase"}, int'(mif.bcm_phase), 0);
  endtask

  initial begin
    vec_t rst_vec;
    int n;
    int bad;
    logic [5:0] w;

    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++)
        for (int p = 0; p < 4; p++) begin
          w = 6'($urandom);
          w[5] = c[0];
          w[0] = c[1];
          pix[r][c][p] = w;
        end

    for (int i = 0; i < NVEC; i++) begin
      tbl[i].row        = (i < 128) ? i / 4 : 0;
      tbl[i].plane      = (i < 128) ? i % 4 : i - 128;
      tbl[i].exp_show   = BASE << tbl[i].plane;
      tbl[i].exp_period = SHIFT_LEN + BLANK + 1 + tbl[i].exp_show;
      tbl[i].exp_fs     = (tbl[i].row == 0 && tbl[i].plane == 0) ? 1 : 0;
      tbl[i].drop_at    = (i == 130) ? 10 : 0;
      tbl[i].idle_after = (i == 130) ? int'($urandom_range(5, 40)) : 0;
    end

    repeat (5) @(negedge clk);
    check_reset_values("hold_reset");

    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      observe_plane(tbl[i]);
      if (tbl[i].idle_after > 0) begin
        chk("idle_next_phase", int'(mif.bcm_phase), (tbl[i].plane + 1) % 4);
        bad = 0;
        for (int k = 0; k < tbl[i].idle_after; k++) begin
          if (p_oe_n !== 1'b1 || p_clk !== 1'b0 || p_lat !== 1'b0) bad++;
          @(negedge clk);
        end
        chk("idle_quiet_errs", bad, 0);
        en = 1'b1;
        @(negedge clk);
      end
    end

    if (fs_times.size() >= 2) chk("frame_interval", fs_times[1] - fs_times[0], 48000);
    else                      chk("frame_pulse_count", fs_times.size(), 2);

    n = 0;
    while (p_oe_n && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_show", int'(p_oe_n), 0);
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_vec = '{row: 0, plane: 0, drop_at: 0, idle_after: 0,
                exp_show: BASE, exp_period: SHIFT_LEN + BLANK + 1 + BASE, exp_fs: 1};
    observe_plane(rst_vec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
